alu_issue_arbiter: RTL and testbench
====================================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares the single combinational ALU between two requesters (req0 = execute stage, req1 = address/aux unit).
//  Round-robin arbitration, one operation in flight, registered ALU operands held stable while executing.
//  Multi-cycle slot for MUL (opcode 4'b1101) to cover the multiplier path; registered response with backpressure.
//  Keeps the architectural flag register {Z,N,V,C}.
// PARAMETERS
//  MUL_CYCLES  2  cycles the ALU inputs are held for MUL before capture (legal 1..7)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst_n       in   1   synchronous reset, active low
//  req0_valid  in   1   requester 0 has a command
//  req0_ready  out  1   requester 0 command accepted this cycle (valid&ready)
//  req0_cmd    in   24  {cin, shift_amt[2:0], opcode[3:0], a[7:0], b[7:0]}
//  req1_valid  in   1   requester 1 has a command
//  req1_ready  out  1   requester 1 command accepted this cycle
//  req1_cmd    in   24  same packing as req0_cmd
//  alu_cmd     out  24  registered command to ALU, same packing
//  alu_res     in   8   ALU result
//  alu_msb     in   8   ALU product high byte (MUL only)
//  alu_flag    in   4   ALU flags {Z,N,V,C}
//  rsp_valid   out  1   response available
//  rsp_ready   in   1   consumer takes response
//  rsp_id      out  1   requester that issued the response (0/1)
//  rsp_res     out  8   captured result
//  rsp_msb     out  8   captured high byte
//  rsp_flag    out  4   captured flags
//  flag_q      out  4   architectural flag register {Z,N,V,C}
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  - Reset (rst_n low at edge): state=IDLE, cmd_q=0 (alu_cmd=0), rsp_valid=0, rsp_id/res/msb/flag=0, flag_q=0,
//    cnt=0, last_grant=1 (so req0 wins first contention). Reset mid-op drops the op; no response issued.
//  - States: IDLE -> EXEC -> HOLD -> IDLE.
//  - IDLE: reqN_ready combinational = (state==IDLE) & grantN. Only valid requester -> granted; both valid ->
//    grant the one != last_grant. Neither valid -> no ready. On accept: cmd_q<=cmd, id_q<=N, last_grant<=N,
//    cnt<=(opcode==4'b1101)?MUL_CYCLES-1:0, go EXEC. At most one ready high per cycle.
//  - EXEC: alu_cmd=cmd_q stable. cnt!=0 -> cnt--. cnt==0 -> capture alu_res/msb/flag into rsp_*,
//    rsp_id<=id_q, rsp_valid<=1, go HOLD.
//  - Latency: accept edge T; non-MUL rsp_valid high after edge T+1; MUL after edge T+MUL_CYCLES.
//  - HOLD: rsp_* stable while rsp_valid & ~rsp_ready. On rsp_ready: rsp_valid<=0, go IDLE. No new accept
//    in HOLD or EXEC; min issue interval 3 cycles.
//  - flag_q <= alu_flag at the capture edge for opcodes 0000-1011 and 1101. Illegal opcodes 1100/1110/1111:
//    still executed and responded (rsp_flag from ALU), flag_q unchanged.
//  - cmd_q is not cleared on return to IDLE; alu_cmd keeps last command.
// TESTING
//  1. req0 ADD a=0x7F b=0x01 cin=0 -> after 1 cycle rsp_valid, rsp_id=0, rsp_res=0x80, rsp_flag=4'b0110, flag_q=4'b0110.
//  2. req1 MUL a=0xFE b=0x03, MUL_CYCLES=2 -> rsp_valid 2 cycles after accept, res=0xFA, msb=0xFF, flag=4'b0100.
//  3. Both valid continuously, rsp_ready=1 -> grants 0,1,0,1; rsp_id alternates; never two readys same cycle.
//  4. ADD 0x01+0x01 then rsp_ready low 5 cycles -> rsp_res=0x02 held, busy=1, req*_ready=0 throughout.
//  5. Illegal opcode 4'b1110 after flag_q=4'b0110 -> rsp_res=0x00, rsp_flag=4'b1000, flag_q stays 4'b0110.
//  6. rst_n low during MUL EXEC -> next cycle state IDLE, rsp_valid=0, flag_q=0, alu_cmd=0, req0 wins next.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter that shares one combinational ALU between two requesters.
// One operation in flight; MUL gets a multi-cycle hold slot; response is registered with backpressure.
module alu_issue_arbiter #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [23:0] req0_cmd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [23:0] req1_cmd,
    output logic [23:0] alu_cmd,
    input  logic [7:0]  alu_res,
    input  logic [7:0]  alu_msb,
    input  logic [3:0]  alu_flag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_res,
    output logic [7:0]  rsp_msb,
    output logic [3:0]  rsp_flag,
    output logic [3:0]  flag_q,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [2:0] MUL_CNT = 3'(MUL_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_cmd;
    logic        r_id;
    logic        r_last_grant;
    logic [2:0]  r_cnt;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [7:0]  r_rsp_res;
    logic [7:0]  r_rsp_msb;
    logic [3:0]  r_rsp_flag;
    logic [3:0]  r_flag;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic [23:0] w_sel_cmd;
    logic        w_capture;
    logic [3:0]  w_op_q;
    logic        w_flag_upd;

    // On contention the requester that did not win last time is granted.
    assign w_grant0   = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1   = req1_valid & (~req0_valid | ~r_last_grant);
    assign req0_ready = (r_state == IDLE) & w_grant0;
    assign req1_ready = (r_state == IDLE) & w_grant1;
    assign w_accept   = req0_ready | req1_ready;
    assign w_sel_cmd  = req1_ready ? req1_cmd : req0_cmd;
    assign w_capture  = (r_state == EXEC) & (r_cnt == 3'd0);
    assign w_op_q     = r_cmd[19:16];
    // Opcodes 1100, 1110 and 1111 are illegal and must not disturb the flag register.
    assign w_flag_upd = ~((w_op_q == 4'b1100) | (w_op_q == 4'b1110) | (w_op_q == 4'b1111));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = EXEC;
            EXEC:    if (r_cnt == 3'd0) w_state_next = HOLD;
            HOLD:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd        <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_res    <= '0;
            r_rsp_msb    <= '0;
            r_rsp_flag   <= '0;
            r_flag       <= '0;
        end else begin
            if (w_accept) begin
                r_cmd        <= w_sel_cmd;
                r_id         <= req1_ready;
                r_last_grant <= req1_ready;
                r_cnt        <= (w_sel_cmd[19:16] == OP_MUL) ? MUL_CNT : 3'd0;
            end
            if ((r_state == EXEC) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_res   <= alu_res;
                r_rsp_msb   <= alu_msb;
                r_rsp_flag  <= alu_flag;
                if (w_flag_upd) begin
                    r_flag <= alu_flag;
                end
            end
            if ((r_state == HOLD) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // The command register is deliberately left holding the last op after it completes.
    assign alu_cmd   = r_cmd;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
    assign rsp_msb   = r_rsp_msb;
    assign rsp_flag  = r_rsp_flag;
    assign flag_q    = r_flag;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter: directed requests push hand-computed responses,
// a negedge monitor pops and compares each response handshake.
module tb_alu_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [23:0] req0_cmd, req1_cmd;
    logic [23:0] alu_cmd;
    logic [7:0]  alu_res, alu_msb;
    logic [3:0]  alu_flag;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [7:0]  rsp_res, rsp_msb;
    logic [3:0]  rsp_flag, flag_q;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic [7:0] msb;
        logic [3:0] flag;
        logic [3:0] fq;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue_arbiter #(.MUL_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
        .alu_cmd(alu_cmd), .alu_res(alu_res), .alu_msb(alu_msb), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_msb(rsp_msb), .rsp_flag(rsp_flag),
        .flag_q(flag_q), .busy(busy)
    );

    // Stand-in ALU: 0000 ADD, 1101 signed MUL, anything else yields zero.
    logic [8:0]  sum9;
    logic [15:0] prod;
    always_comb begin
        sum9     = '0;
        prod     = '0;
        alu_res  = '0;
        alu_msb  = '0;
        alu_flag = '0;
        case (alu_cmd[19:16])
            4'b0000: begin
                sum9        = {1'b0, alu_cmd[15:8]} + {1'b0, alu_cmd[7:0]} + {8'd0, alu_cmd[23]};
                alu_res     = sum9[7:0];
                alu_flag[0] = sum9[8];
                alu_flag[1] = (alu_cmd[15] == alu_cmd[7]) && (sum9[7] != alu_cmd[15]);
            end
            4'b1101: begin
                prod        = 16'($signed(alu_cmd[15:8]) * $signed(alu_cmd[7:0]));
                alu_res     = prod[7:0];
                alu_msb     = prod[15:8];
                alu_flag[1] = (prod[15:8] != {8{prod[7]}});
                alu_flag[0] = alu_flag[1];
            end
            default: ;
        endcase
        alu_flag[3] = (alu_res == 8'd0);
        alu_flag[2] = alu_res[7];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] mk(input logic cin, input logic [2:0] sh, input logic [3:0] op,
                                       input logic [7:0] a, input logic [7:0] b);
        return {cin, sh, op, a, b};
    endfunction

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id=%0d res=%h with no expected entry", rsp_id, rsp_res);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp{id,res,msb,flag,flag_q}", {7'd0, rsp_id, rsp_res, rsp_msb, rsp_flag, flag_q}, {7'd0, e});
                $display("[TB] rsp id=%0d res=%h msb=%h flag=%b flag_q=%b", rsp_id, rsp_res, rsp_msb, rsp_flag, flag_q);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge where rsp_valid is seen (or after accept if lat==0).
    task automatic issue(input int n, input logic [23:0] cmd, input logic do_push, input exp_t e, input int lat);
        bit acc;
        int k;
        acc = 1'b0;
        k   = 0;
        if (n == 0) begin req0_valid = 1'b1; req0_cmd = cmd; end
        else        begin req1_valid = 1'b1; req1_cmd = cmd; end
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
                acc = 1'b1;
                if (do_push) sb.push_back(e);
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no ready for req%0d expected ready within 40 cycles", n);
            return;
        end
        $display("[TB] req%0d accepted cmd=%h", n, cmd);
        chk("alu_cmd_held", alu_cmd, cmd);
        if (lat > 0) begin
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); #1;
                if (rsp_valid) begin k = i; break; end
            end
            chk("latency", k, lat);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk); #1;
            if (!busy && sb.size() == 0) done = 1'b1;
        end
        chk("drained_idle", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_id [4];
        int   grants;
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_cmd = '0; req1_cmd = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_cmd", alu_cmd, 0);
        chk("rst_flag_q", flag_q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_res", rsp_res, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_ready", {req0_ready, req1_ready}, 0);

        // ADD 7F+01 -> 80, V and N set
        rsp_ready = 1'b1;
        issue(0, mk(1'b0, 3'd0, 4'b0000, 8'h7F, 8'h01), 1'b1,
              exp_t'({1'b0, 8'h80, 8'h00, 4'b0110, 4'b0110}), 1);
        wait_idle();

        // MUL FE*03 = -6 -> FFFA
        issue(1, mk(1'b0, 3'd0, 4'b1101, 8'hFE, 8'h03), 1'b1,
              exp_t'({1'b1, 8'hFA, 8'hFF, 4'b0100, 4'b0100}), 2);
        wait_idle();

        // Backpressure: hold response for 5 cycles while both requesters wait
        rsp_ready = 1'b0;
        issue(0, mk(1'b0, 3'd0, 4'b0000, 8'h01, 8'h01), 1'b1,
              exp_t'({1'b0, 8'h02, 8'h00, 4'b0000, 4'b0000}), 1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_res", rsp_res, 8'h02);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_busy", busy, 1);
            chk("hold_no_ready", {req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        // Illegal opcode must leave flag_q untouched
        issue(0, mk(1'b0, 3'd0, 4'b0000, 8'h7F, 8'h01), 1'b1,
              exp_t'({1'b0, 8'h80, 8'h00, 4'b0110, 4'b0110}), 1);
        wait_idle();
        issue(0, mk(1'b0, 3'd0, 4'b1110, 8'h33, 8'h44), 1'b1,
              exp_t'({1'b0, 8'h00, 8'h00, 4'b1000, 4'b0110}), 1);
        wait_idle();

        // Reset in the middle of a MUL drops it
        issue(0, mk(1'b0, 3'd0, 4'b1101, 8'h05, 8'h06), 1'b0, exp_t'(25'd0), 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_flag_q", flag_q, 0);
        chk("midrst_alu_cmd", alu_cmd, 0);
        chk("midrst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_rsp", rsp_valid, 0);
        chk("midrst_idle", busy, 0);

        // Continuous contention after reset: 0,1,0,1
        sb.push_back(exp_t'({1'b0, 8'h30, 8'h00, 4'b0000, 4'b0000}));
        sb.push_back(exp_t'({1'b1, 8'h00, 8'h00, 4'b1001, 4'b1001}));
        sb.push_back(exp_t'({1'b0, 8'h30, 8'h00, 4'b0000, 4'b0000}));
        sb.push_back(exp_t'({1'b1, 8'h00, 8'h00, 4'b1001, 4'b1001}));
        req0_cmd = mk(1'b0, 3'd0, 4'b0000, 8'h10, 8'h20);
        req1_cmd = mk(1'b0, 3'd0, 4'b0000, 8'hFF, 8'h01);
        req0_valid = 1'b1; req1_valid = 1'b1;
        grants = 0;
        for (int c = 0; c < 60 && grants < 4; c++) begin
            @(negedge clk);
            chk("one_ready", {31'd0, req0_ready & req1_ready}, 0);
            if (req0_ready || req1_ready) begin
                chk("grant_order", req1_ready, exp_id[grants]);
                $display("[TB] grant %0d to req%0d", grants, req1_ready);
                grants++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("grant_count", grants, 4);
        wait_idle();

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
